// File: rtl/calc1_port_checker.sv
// Per-port response checker for the calc1 DUV.
// It snoops a two-cycle request, predicts the response, and judges the DUV's reply.
module calc1_port_checker #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [3:0]       req_cmd_in,
  input  logic [31:0]      req_data_in,
  input  logic [1:0]       out_resp_in,
  input  logic [31:0]      out_data_in,
  output logic             chk_done,
  output logic             chk_pass,
  output logic             chk_timeout,
  output logic [1:0]       exp_resp,
  output logic [31:0]      exp_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             proto_err
);

  // state  | meaning
  // IDLE   | waiting for a command; a response here is stray
  // OP2    | operand 2 on the bus; expectations computed this cycle
  // WAIT   | waiting for the DUV response or timeout
  // REPORT | verdict published next edge; also accepts a new command
  typedef enum logic [1:0] {IDLE, OP2, WAIT, REPORT} state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  state_t           state, state_nxt;
  logic [3:0]       cmd_q;
  logic [31:0]      op1_q;
  logic [TMR_W-1:0] tmr;
  logic             pend_pass, pend_to;

  logic capture, load_exp, stray, judge, timed_out, report, proto_set;
  logic resp_ok;
  logic [1:0]  exp_resp_nxt;
  logic [31:0] exp_data_nxt;
  logic [32:0] sum;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_exp  = 1'b0;
    stray     = 1'b0;
    judge     = 1'b0;
    timed_out = 1'b0;
    report    = 1'b0;
    proto_set = 1'b0;
    case (state)
      IDLE: begin
        if (req_cmd_in != 4'd0) begin
          capture   = 1'b1;
          state_nxt = OP2;
        end
        if (out_resp_in != 2'd0) begin
          stray     = 1'b1;
          proto_set = 1'b1;
        end
      end
      OP2: begin
        load_exp  = 1'b1;
        state_nxt = WAIT;
        if (req_cmd_in != 4'd0) proto_set = 1'b1;
        if (out_resp_in != 2'd0) begin
          stray     = 1'b1;
          proto_set = 1'b1;
        end
      end
      WAIT: begin
        if (req_cmd_in != 4'd0) proto_set = 1'b1;
        if (out_resp_in != 2'd0) begin
          judge     = 1'b1;
          state_nxt = REPORT;
        end else if (tmr == TMR_W'(1)) begin
          timed_out = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        report    = 1'b1;
        state_nxt = IDLE;
        if (req_cmd_in != 4'd0) begin
          capture   = 1'b1;
          state_nxt = OP2;
        end
        // Only one counter may move per cycle, so a response here is flagged but not counted.
        if (out_resp_in != 2'd0) proto_set = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum          = {1'b0, op1_q} + {1'b0, req_data_in};
    exp_resp_nxt = 2'd3;
    exp_data_nxt = 32'd0;
    case (cmd_q)
      CMD_ADD: begin
        exp_resp_nxt = sum[32] ? 2'd2 : 2'd1;
        exp_data_nxt = sum[31:0];
      end
      CMD_SUB: begin
        exp_resp_nxt = (req_data_in > op1_q) ? 2'd2 : 2'd1;
        exp_data_nxt = op1_q - req_data_in;
      end
      CMD_LSH: begin
        exp_resp_nxt = 2'd1;
        exp_data_nxt = op1_q << req_data_in[4:0];
      end
      CMD_RSH: begin
        exp_resp_nxt = 2'd1;
        exp_data_nxt = op1_q >> req_data_in[4:0];
      end
      default: begin
        exp_resp_nxt = 2'd3;
        exp_data_nxt = 32'd0;
      end
    endcase
  end

  assign resp_ok = (out_resp_in == exp_resp) &&
                   ((exp_resp != 2'd1) || (out_data_in == exp_data));

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= 4'd0;
      op1_q       <= 32'd0;
      exp_resp    <= 2'd0;
      exp_data    <= 32'd0;
      tmr         <= '0;
      pend_pass   <= 1'b0;
      pend_to     <= 1'b0;
      chk_done    <= 1'b0;
      chk_pass    <= 1'b0;
      chk_timeout <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (capture) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
      end
      if (load_exp) begin
        exp_resp <= exp_resp_nxt;
        exp_data <= exp_data_nxt;
        tmr      <= TMR_W'(TIMEOUT);
      end else if (state == WAIT && tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end
      if (judge) begin
        pend_pass <= resp_ok;
        pend_to   <= 1'b0;
      end else if (timed_out) begin
        pend_pass <= 1'b0;
        pend_to   <= 1'b1;
      end
      chk_done <= report;
      if (report) begin
        chk_pass    <= pend_pass;
        chk_timeout <= pend_to;
      end
      if (report && pend_pass && pass_cnt != '1)
        pass_cnt <= pass_cnt + CNT_W'(1);
      if ((stray || (report && !pend_pass)) && fail_cnt != '1)
        fail_cnt <= fail_cnt + CNT_W'(1);
      if (proto_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_port_checker.sv
// Directed self-checking bench for calc1_port_checker.
// Counters are built 4 bits wide so saturation is reachable in a few cycles.
module tb_calc1_port_checker;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic             c_clk;
  logic             reset;
  logic [3:0]       req_cmd_in;
  logic [31:0]      req_data_in;
  logic [1:0]       out_resp_in;
  logic [31:0]      out_data_in;
  logic             chk_done, chk_pass, chk_timeout;
  logic [1:0]       exp_resp;
  logic [31:0]      exp_data;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic             proto_err;

  int checks = 0;
  int errors = 0;

  calc1_port_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp_in(out_resp_in),
    .out_data_in(out_data_in),
    .chk_done   (chk_done),
    .chk_pass   (chk_pass),
    .chk_timeout(chk_timeout),
    .exp_resp   (exp_resp),
    .exp_data   (exp_data),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .proto_err  (proto_err)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    req_cmd_in  = cmd;
    req_data_in = op1;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = op2;
    tick();
    req_data_in = 32'd0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d);
    out_resp_in = r;
    out_data_in = d;
    tick();
    out_resp_in = 2'd0;
    out_data_in = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_cmd_in = 4'd0; req_data_in = 32'd0; out_resp_in = 2'd0; out_data_in = 32'd0;
    repeat (3) tick();
    checks++;
    if ({chk_done, chk_pass, chk_timeout, proto_err, exp_resp, exp_data, pass_cnt, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b pass=%b to=%b perr=%b er=%0d ed=%h pc=%0d fc=%0d required all zero",
               chk_done, chk_pass, chk_timeout, proto_err, exp_resp, exp_data, pass_cnt, fail_cnt);
    end
    #2 reset = 1'b1;
    tick();
    checks++;
    if (chk_done !== 1'b0) begin errors++; $display("FAIL reset_idle_done: got %b required 0", chk_done); end
  endtask

  task automatic test_add_pass();
    issue(4'd1, 32'h0000FFFF, 32'h00000001);
    checks++;
    if (exp_resp !== 2'd1) begin errors++; $display("FAIL add_exp_resp: got %0d required 1", exp_resp); end
    checks++;
    if (exp_data !== 32'h00010000) begin errors++; $display("FAIL add_exp_data: got %h required 00010000", exp_data); end
    tick(); tick();
    respond(2'd1, 32'h00010000);
    checks++;
    if (chk_done !== 1'b0) begin errors++; $display("FAIL add_done_early: got %b required 0", chk_done); end
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1) begin
      errors++; $display("FAIL add_verdict: got done=%b pass=%b required done=1 pass=1", chk_done, chk_pass);
    end
    checks++;
    if (pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
      errors++; $display("FAIL add_counts: got pc=%0d fc=%0d required pc=1 fc=0", pass_cnt, fail_cnt);
    end
    tick();
    checks++;
    if (chk_done !== 1'b0 || chk_pass !== 1'b1) begin
      errors++; $display("FAIL add_pulse_hold: got done=%b pass=%b required done=0 pass=1", chk_done, chk_pass);
    end
  endtask

  task automatic test_add_overflow();
    issue(4'd1, 32'hFFFFFFFF, 32'h00000001);
    checks++;
    if (exp_resp !== 2'd2) begin errors++; $display("FAIL ovf_exp_resp: got %0d required 2", exp_resp); end
    respond(2'd1, 32'h00000000);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b0 || chk_timeout !== 1'b0) begin
      errors++; $display("FAIL ovf_verdict: got done=%b pass=%b to=%b required 1 0 0", chk_done, chk_pass, chk_timeout);
    end
    checks++;
    if (fail_cnt !== 4'd1 || pass_cnt !== 4'd1) begin
      errors++; $display("FAIL ovf_counts: got pc=%0d fc=%0d required pc=1 fc=1", pass_cnt, fail_cnt);
    end
    tick();
  endtask

  task automatic test_shifts();
    issue(4'd6, 32'h80000000, 32'd31);
    checks++;
    if (exp_resp !== 2'd1 || exp_data !== 32'h00000001) begin
      errors++; $display("FAIL rsh_exp: got resp=%0d data=%h required 1 00000001", exp_resp, exp_data);
    end
    respond(2'd1, 32'h00000001);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1) begin
      errors++; $display("FAIL rsh_verdict: got done=%b pass=%b required 1 1", chk_done, chk_pass);
    end
    tick();
    issue(4'd5, 32'hFFFFFFFF, 32'd32);
    checks++;
    if (exp_resp !== 2'd1 || exp_data !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL lsh_exp: got resp=%0d data=%h required 1 ffffffff", exp_resp, exp_data);
    end
    respond(2'd1, 32'hFFFFFFFF);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1 || pass_cnt !== 4'd3) begin
      errors++; $display("FAIL lsh_verdict: got done=%b pass=%b pc=%0d required 1 1 3", chk_done, chk_pass, pass_cnt);
    end
    tick();
  endtask

  task automatic test_data_mismatch();
    issue(4'd2, 32'd10, 32'd3);
    checks++;
    if (exp_resp !== 2'd1 || exp_data !== 32'd7) begin
      errors++; $display("FAIL sub_exp: got resp=%0d data=%h required 1 00000007", exp_resp, exp_data);
    end
    respond(2'd1, 32'd8);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b0 || fail_cnt !== 4'd2) begin
      errors++; $display("FAIL data_mismatch: got done=%b pass=%b fc=%0d required 1 0 2", chk_done, chk_pass, fail_cnt);
    end
    tick();
  endtask

  task automatic test_sub_invalid();
    issue(4'd2, 32'h00000000, 32'h00000001);
    checks++;
    if (exp_resp !== 2'd2) begin errors++; $display("FAIL sub_under_exp: got %0d required 2", exp_resp); end
    respond(2'd2, 32'h12345678);
    tick();
    checks++;
    if (chk_pass !== 1'b1 || pass_cnt !== 4'd4) begin
      errors++; $display("FAIL sub_under_verdict: got pass=%b pc=%0d required 1 4", chk_pass, pass_cnt);
    end
    tick();
    issue(4'd4, 32'h11111111, 32'h22222222);
    checks++;
    if (exp_resp !== 2'd3) begin errors++; $display("FAIL invalid_exp: got %0d required 3", exp_resp); end
    respond(2'd3, 32'hDEADBEEF);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1 || pass_cnt !== 4'd5) begin
      errors++; $display("FAIL invalid_verdict: got done=%b pass=%b pc=%0d required 1 1 5", chk_done, chk_pass, pass_cnt);
    end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b required 0", proto_err); end
    tick();
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    issue(4'd1, 32'd1, 32'd2);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (chk_done === 1'b1) begin
        seen = i;
        break;
      end
    end
    checks++;
    if (seen !== TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles required %0d", seen, TIMEOUT + 1);
    end
    checks++;
    if (chk_timeout !== 1'b1 || chk_pass !== 1'b0 || fail_cnt !== 4'd3) begin
      errors++; $display("FAIL timeout_verdict: got to=%b pass=%b fc=%0d required 1 0 3", chk_timeout, chk_pass, fail_cnt);
    end
    tick();
  endtask

  task automatic test_proto_wait();
    issue(4'd2, 32'd5, 32'd3);
    req_cmd_in = 4'd1; req_data_in = 32'h0000AAAA;
    tick();
    req_cmd_in = 4'd0; req_data_in = 32'h0000BBBB;
    tick();
    req_data_in = 32'd0;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_wait_flag: got %b required 1", proto_err); end
    checks++;
    if (exp_data !== 32'd2) begin errors++; $display("FAIL proto_wait_untracked: got %h required 00000002", exp_data); end
    respond(2'd1, 32'd2);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1 || chk_timeout !== 1'b0 || pass_cnt !== 4'd6) begin
      errors++; $display("FAIL proto_wait_verdict: got done=%b pass=%b to=%b pc=%0d required 1 1 0 6",
                         chk_done, chk_pass, chk_timeout, pass_cnt);
    end
    repeat (4) tick();
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b required 1", proto_err); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    issue(4'd1, 32'd7, 32'd8);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({chk_pass, chk_timeout, proto_err, exp_resp, exp_data, pass_cnt, fail_cnt} !== '0) begin
      errors++; $display("FAIL reset_mid_clear: got pass=%b to=%b perr=%b er=%0d ed=%h pc=%0d fc=%0d required all zero",
                         chk_pass, chk_timeout, proto_err, exp_resp, exp_data, pass_cnt, fail_cnt);
    end
    tick(); tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (chk_done === 1'b1) seen_done = 1;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL reset_mid_no_done: got chk_done seen=%0d required 0", seen_done); end
  endtask

  task automatic test_stray();
    respond(2'd2, 32'h0);
    checks++;
    if (fail_cnt !== 4'd1 || proto_err !== 1'b1 || chk_done !== 1'b0) begin
      errors++; $display("FAIL stray_idle: got fc=%0d perr=%b done=%b required 1 1 0", fail_cnt, proto_err, chk_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(4'd1, 32'd1, 32'd1);
    out_resp_in = 2'd1; out_data_in = 32'd2;
    tick();
    out_resp_in = 2'd0; out_data_in = 32'd0;
    req_cmd_in = 4'd1; req_data_in = 32'd3;
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1 || pass_cnt !== 4'd1) begin
      errors++; $display("FAIL b2b_first: got done=%b pass=%b pc=%0d required 1 1 1", chk_done, chk_pass, pass_cnt);
    end
    req_cmd_in = 4'd0; req_data_in = 32'd4;
    tick();
    req_data_in = 32'd0;
    checks++;
    if (exp_resp !== 2'd1 || exp_data !== 32'd7) begin
      errors++; $display("FAIL b2b_capture: got resp=%0d data=%h required 1 00000007", exp_resp, exp_data);
    end
    respond(2'd1, 32'd7);
    tick();
    checks++;
    if (chk_done !== 1'b1 || chk_pass !== 1'b1 || pass_cnt !== 4'd2) begin
      errors++; $display("FAIL b2b_second: got done=%b pass=%b pc=%0d required 1 1 2", chk_done, chk_pass, pass_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    out_resp_in = 2'd1;
    repeat (20) tick();
    out_resp_in = 2'd0;
    tick();
    checks++;
    if (fail_cnt !== 4'hF || pass_cnt !== 4'd2) begin
      errors++; $display("FAIL saturation: got fc=%0d pc=%0d required 15 2", fail_cnt, pass_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_add_overflow();
    test_shifts();
    test_data_mismatch();
    test_sub_invalid();
    test_timeout();
    test_proto_wait();
    test_reset_mid();
    test_stray();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
